// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default stage widths for pipeline_skid_reg
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Per-boundary widths: E->M carries AluResult, WriteData and WA3, padded.
  localparam int CTRL_W_EM = 4;
  localparam int DATA_W_EM = 72;
  localparam int CTRL_W_MW = 2;
  localparam int DATA_W_MW = 72;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one held pipeline entry: ctrl and data registers with load and ctrl-clear
module pipe_entry_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 72
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_clr_ctrl,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Clearing only touches ctrl, so squashed entries become bubbles while data keeps its last value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else begin
      if (i_clr_ctrl) begin
        r_ctrl <= '0;
      end else if (i_load) begin
        r_ctrl <= i_ctrl;
      end
      if (i_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/pipeline_skid_reg.sv
// rtl/pipeline_skid_reg.sv - valid/ready pipeline boundary with two-entry skid, flush and stall counter
module pipeline_skid_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_EM,
  parameter int DATA_W = DATA_W_EM,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_asynchronous,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [CTRL_W-1:0] o_out_ctrl,
  output logic [DATA_W-1:0] o_out_data,
  input  logic              i_stats_clear,
  output logic [CNT_W-1:0]  o_stall_count
);

  state_t r_state;
  state_t w_next_state;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_load;
  logic              w_main_from_skid;
  logic              w_main_clr;
  logic              w_skid_load;
  logic              w_skid_clr;
  logic [CTRL_W-1:0] w_main_d_ctrl;
  logic [DATA_W-1:0] w_main_d_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic [CNT_W-1:0]  r_stall_count;

  assign o_in_ready  = (r_state != ST_TWO) & ~i_flush;
  assign o_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = i_in_valid & o_in_ready;
  assign w_out_fire  = o_out_valid & i_out_ready;

  always_ff @(posedge i_clk or posedge i_reset_asynchronous) begin
    if (i_reset_asynchronous) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_clr       = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clr       = 1'b0;
    if (i_flush) begin
      w_next_state = ST_EMPTY;
      w_main_clr   = 1'b1;
      w_skid_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_load  = 1'b1;
            w_next_state = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_load = 1'b1;
          end else if (w_in_fire) begin
            w_skid_load  = 1'b1;
            w_next_state = ST_TWO;
          end else if (w_out_fire) begin
            w_main_clr   = 1'b1;
            w_next_state = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clr       = 1'b1;
            w_next_state     = ST_ONE;
          end
        end
        default: begin
          w_next_state = ST_EMPTY;
          w_main_clr   = 1'b1;
          w_skid_clr   = 1'b1;
        end
      endcase
    end
  end

  assign w_main_d_ctrl = w_main_from_skid ? w_skid_ctrl : i_in_ctrl;
  assign w_main_d_data = w_main_from_skid ? w_skid_data : i_in_data;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .i_clk      (i_clk),
    .i_rst      (i_reset_asynchronous),
    .i_load     (w_main_load),
    .i_clr_ctrl (w_main_clr),
    .i_ctrl     (w_main_d_ctrl),
    .i_data     (w_main_d_data),
    .o_ctrl     (o_out_ctrl),
    .o_data     (o_out_data)
  );

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .i_clk      (i_clk),
    .i_rst      (i_reset_asynchronous),
    .i_load     (w_skid_load),
    .i_clr_ctrl (w_skid_clr),
    .i_ctrl     (i_in_ctrl),
    .i_data     (i_in_data),
    .o_ctrl     (w_skid_ctrl),
    .o_data     (w_skid_data)
  );

  always_ff @(posedge i_clk or posedge i_reset_asynchronous) begin
    if (i_reset_asynchronous) begin
      r_stall_count <= '0;
    end else if (i_stats_clear) begin
      r_stall_count <= '0;
    end else if (o_out_valid && !i_out_ready && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// tb/tb_pipeline_skid_reg.sv - directed self-checking bench for pipeline_skid_reg
module tb_pipeline_skid_reg;

  localparam int CW = 4;
  localparam int DW = 72;
  localparam int NW = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic          stats_clear;
  logic [NW-1:0] stall_count;

  int total;
  int bad;

  pipeline_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .i_clk                (clk),
    .i_reset_asynchronous (rst),
    .i_flush              (flush),
    .i_in_valid           (in_valid),
    .o_in_ready           (in_ready),
    .i_in_ctrl            (in_ctrl),
    .i_in_data            (in_data),
    .o_out_valid          (out_valid),
    .i_out_ready          (out_ready),
    .o_out_ctrl           (out_ctrl),
    .o_out_data           (out_data),
    .i_stats_clear        (stats_clear),
    .o_stall_count        (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; stats_clear = 1'b0;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (out_ctrl !== 4'h0) begin bad++; $display("FAIL reset_out_ctrl got=%0h exp=0", out_ctrl); end
    total++; if (out_data !== 72'h0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if (stall_count !== 4'h0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_count); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 4'hF;
    for (int i = 1; i <= 3; i++) begin
      in_data = DW'(i);
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== DW'(i) || out_ctrl !== 4'hF) begin
        bad++; $display("FAIL stream_out_%0d got v=%0b d=%0h c=%0h exp v=1 d=%0h c=f", i, out_valid, out_data, out_ctrl, i);
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready_%0d got=%0b exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || out_data !== 72'h3) begin
      bad++; $display("FAIL stream_drain got v=%0b c=%0h d=%0h exp v=0 c=0 d=3", out_valid, out_ctrl, out_data);
    end
    total++; if (stall_count !== 4'h0) begin bad++; $display("FAIL stream_stall got=%0d exp=0", stall_count); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 4'h5;
    in_data   = 72'hA;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 72'hA || in_ready !== 1'b1 || stall_count !== 4'd0) begin
      bad++; $display("FAIL bp_first got v=%0b d=%0h r=%0b s=%0d exp v=1 d=a r=1 s=0", out_valid, out_data, in_ready, stall_count);
    end
    in_ctrl = 4'h6;
    in_data = 72'hB;
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || out_data !== 72'hA || out_ctrl !== 4'h5 || stall_count !== 4'd1) begin
      bad++; $display("FAIL bp_two got r=%0b d=%0h c=%0h s=%0d exp r=0 d=a c=5 s=1", in_ready, out_data, out_ctrl, stall_count);
    end
    tick();
    total++; if (in_ready !== 1'b0 || stall_count !== 4'd2) begin
      bad++; $display("FAIL bp_hold got r=%0b s=%0d exp r=0 s=2", in_ready, stall_count);
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 72'hB || out_ctrl !== 4'h6 || in_ready !== 1'b1 || stall_count !== 4'd2) begin
      bad++; $display("FAIL bp_release_b got v=%0b d=%0h c=%0h r=%0b s=%0d exp v=1 d=b c=6 r=1 s=2", out_valid, out_data, out_ctrl, in_ready, stall_count);
    end
    tick();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0) begin
      bad++; $display("FAIL bp_empty got v=%0b c=%0h exp v=0 c=0", out_valid, out_ctrl);
    end
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    total++; if (stall_count !== 4'd0) begin bad++; $display("FAIL bp_clear got=%0d exp=0", stall_count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 4'h3;
    in_data   = 72'hA;
    tick();
    in_data = 72'hB;
    tick();
    in_data = 72'hC;
    flush   = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || out_data !== 72'hA) begin
      bad++; $display("FAIL flush_out got v=%0b c=%0h d=%0h exp v=0 c=0 d=a", out_valid, out_ctrl, out_data);
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || out_data === 72'hC || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_after got v=%0b d=%0h r=%0b exp v=0 d!=c r=1", out_valid, out_data, in_ready);
    end
  endtask

  task automatic test_saturation();
    out_ready   = 1'b0;
    stats_clear = 1'b1;
    in_valid    = 1'b1;
    in_ctrl     = 4'h9;
    in_data     = 72'hD;
    tick();
    stats_clear = 1'b0;
    in_valid    = 1'b0;
    total++; if (stall_count !== 4'd0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL sat_start got s=%0d v=%0b exp s=0 v=1", stall_count, out_valid);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 4) begin
        total++; if (stall_count !== 4'd5) begin bad++; $display("FAIL sat_mid got=%0d exp=5", stall_count); end
      end
    end
    total++; if (stall_count !== 4'd15) begin bad++; $display("FAIL sat_top got=%0d exp=15", stall_count); end
    tick();
    total++; if (stall_count !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", stall_count); end
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    total++; if (stall_count !== 4'd0) begin bad++; $display("FAIL sat_clear got=%0d exp=0", stall_count); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    in_ctrl  = 4'h7;
    in_data  = 72'hE;
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (in_ready !== 1'b0 || stall_count !== 4'd2) begin
      bad++; $display("FAIL arst_pre got r=%0b s=%0d exp r=0 s=2", in_ready, stall_count);
    end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || out_data !== 72'h0 || stall_count !== 4'd0) begin
      bad++; $display("FAIL arst_now got v=%0b c=%0h d=%0h s=%0d exp all 0", out_valid, out_ctrl, out_data, stall_count);
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%0b exp=1", in_ready); end
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 4'h1;
    in_data   = 72'h7;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 72'h7 || out_ctrl !== 4'h1) begin
      bad++; $display("FAIL arst_first_accept got v=%0b d=%0h c=%0h exp v=1 d=7 c=1", out_valid, out_data, out_ctrl);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_streaming();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
